// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative
// multiply/divide unit. The EX stage drives the request side, the unit
// answers with a one-cycle response pulse and a held result.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            muldiv_start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            muldiv_resp;
   logic [XLEN-1:0] muldiv_out;
   logic            muldiv_busy;

   modport master (
      output muldiv_start, funct3, rs1_data, rs2_data,
      input  muldiv_resp, muldiv_out, muldiv_busy
   );

   modport slave (
      input  muldiv_start, funct3, rs1_data, rs2_data,
      output muldiv_resp, muldiv_out, muldiv_busy
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operates on unsigned magnitudes,
// one bit per cycle (shift-add multiply, restoring divide), and applies
// the sign fixup in the same cycle the result register is written.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t state, state_next;

   logic [2:0]        op;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              a_neg;
   logic              res_neg;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quot;
   logic [CNT_W-1:0]  cnt;

   logic              req_a_signed;
   logic              req_b_signed;
   logic              req_a_neg;
   logic              req_b_neg;
   logic [XLEN-1:0]   req_a_mag;
   logic [XLEN-1:0]   req_b_mag;
   logic              req_div_zero;
   logic              req_div_ovf;
   logic              req_special;
   logic [XLEN-1:0]   req_special_result;

   logic              start_accept;
   logic              last_iter;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic              div_ok;
   logic [XLEN-1:0]   rem_step;
   logic [XLEN-1:0]   quot_step;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   busy_result;

   assign start_accept = (state == IDLE) && bus.muldiv_start;
   assign last_iter    = (cnt == CNT_W'(XLEN-1));

   // Decode the incoming request: operand signedness, magnitudes and the
   // two divide corner cases whose results are known without iterating.
   always_comb begin
      req_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      req_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                     (bus.funct3 == 3'b110);
      req_a_neg    = req_a_signed && bus.rs1_data[XLEN-1];
      req_b_neg    = req_b_signed && bus.rs2_data[XLEN-1];
      req_a_mag    = req_a_neg ? -bus.rs1_data : bus.rs1_data;
      req_b_mag    = req_b_neg ? -bus.rs2_data : bus.rs2_data;
      req_div_zero = bus.funct3[2] && (bus.rs2_data == '0);
      req_div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                     (bus.rs1_data == MIN_INT) && (bus.rs2_data == '1);
      req_special  = req_div_zero || req_div_ovf;
      req_special_result = '0;
      if (req_div_zero)
         req_special_result = bus.funct3[1] ? bus.rs1_data : '1;
      else if (req_div_ovf)
         req_special_result = bus.funct3[1] ? '0 : MIN_INT;
   end

   // One iteration of both datapaths plus the signed result that would be
   // written if this is the final iteration.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
      acc_step  = {mul_sum, acc[XLEN-1:1]};
      div_shift = {rem, quot[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_mag};
      div_ok    = !div_diff[XLEN];
      rem_step  = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      quot_step = {quot[XLEN-2:0], div_ok};
      prod_fix  = res_neg ? -acc_step : acc_step;
      quot_fix  = res_neg ? -quot_step : quot_step;
      rem_fix   = a_neg ? -rem_step : rem_step;
      busy_result = '0;
      case (op)
         3'b000:                 busy_result = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: busy_result = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         busy_result = quot_fix;
         default:                busy_result = rem_fix;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; DONE always returns to IDLE so a held start is not
   // taken twice for the same instruction.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.muldiv_start)
               state_next = req_special ? DONE : BUSY;
         end
         BUSY: begin
            if (last_iter)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand latch on accept, then one multiply/divide step per BUSY cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op      <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         a_neg   <= 1'b0;
         res_neg <= 1'b0;
         acc     <= '0;
         rem     <= '0;
         quot    <= '0;
         cnt     <= '0;
      end else if (start_accept) begin
         op      <= bus.funct3;
         a_mag   <= req_a_mag;
         b_mag   <= req_b_mag;
         a_neg   <= req_a_neg;
         res_neg <= req_a_neg ^ req_b_neg;
         acc     <= {{XLEN{1'b0}}, req_b_mag};
         rem     <= '0;
         quot    <= req_a_mag;
         cnt     <= '0;
      end else if (state == BUSY) begin
         acc     <= acc_step;
         rem     <= rem_step;
         quot    <= quot_step;
         cnt     <= cnt + 1'b1;
      end
   end

   // Registered outputs: result written on entry to DONE, pulse and busy
   // follow the next state so they line up with the DONE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.muldiv_out  <= '0;
         bus.muldiv_resp <= 1'b0;
         bus.muldiv_busy <= 1'b0;
      end else begin
         bus.muldiv_resp <= (state_next == DONE);
         bus.muldiv_busy <= (state_next != IDLE);
         if (start_accept && req_special)
            bus.muldiv_out <= req_special_result;
         else if ((state == BUSY) && last_iter)
            bus.muldiv_out <= busy_result;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized
// operations against an arithmetic reference model, back-to-back issue
// with a held start, and reset in the middle of an operation.
module tb_muldiv_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   muldiv_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference result computed directly from the RV32M definitions.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb;
      logic [63:0] p;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      case (f)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return ia / ib;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, drop start after acceptance while scrambling the inputs,
   // then check busy, latency, result, single pulse and held result.
   task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
      logic [31:0] exp_val;
      logic [31:0] got;
      int          exp_lat;
      int          lat;
      exp_val = ref_model(f, a, b);
      exp_lat = ref_latency(f, a, b);
      @(negedge clk);
      bus.muldiv_start = 1'b1;
      bus.funct3       = f;
      bus.rs1_data     = a;
      bus.rs2_data     = b;
      @(posedge clk);
      lat = 0;
      got = '0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) check_output({tag, " busy"}, 32'(bus.muldiv_busy), 32'd1);
         if (bus.muldiv_resp) begin
            lat = k;
            got = bus.muldiv_out;
         end
         if (k == 1) begin
            bus.muldiv_start = 1'b0;
            bus.funct3       = 3'($urandom);
            bus.rs1_data     = $urandom;
            bus.rs2_data     = $urandom;
         end
      end
      check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_output({tag, " result"}, got, exp_val);
      @(negedge clk);
      check_output({tag, " single pulse"}, 32'(bus.muldiv_resp), 32'd0);
      check_output({tag, " held"}, bus.muldiv_out, exp_val);
   endtask

   // Two ops issued with start held high across the response.
   task automatic back_to_back(input logic [2:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [2:0] f2, input logic [31:0] a2, input logic [31:0] b2);
      int          n_resp;
      int          k1;
      int          k2;
      logic [31:0] got1;
      logic [31:0] got2;
      n_resp = 0;
      k1 = 0;
      k2 = 0;
      got1 = '0;
      got2 = '0;
      @(negedge clk);
      bus.muldiv_start = 1'b1;
      bus.funct3       = f1;
      bus.rs1_data     = a1;
      bus.rs2_data     = b1;
      @(posedge clk);
      for (int k = 1; k <= 90; k++) begin
         @(negedge clk);
         if (bus.muldiv_resp) begin
            n_resp++;
            if (n_resp == 1) begin
               k1 = k;
               got1 = bus.muldiv_out;
               bus.funct3   = f2;
               bus.rs1_data = a2;
               bus.rs2_data = b2;
            end else if (n_resp == 2) begin
               k2 = k;
               got2 = bus.muldiv_out;
            end
         end
         if (k1 != 0 && k == k1 + 2) bus.muldiv_start = 1'b0;
      end
      bus.muldiv_start = 1'b0;
      check_output("b2b resp count", 32'(n_resp), 32'd2);
      check_output("b2b first latency", 32'(k1), 32'd33);
      check_output("b2b first result", got1, ref_model(f1, a1, b1));
      check_output("b2b second latency", 32'(k2), 32'd67);
      check_output("b2b second result", got2, ref_model(f2, a2, b2));
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int          pick;
      int          stray;
      n_cmp  = 0;
      n_fail = 0;
      clk    = 1'b0;
      rst    = 1'b1;
      bus.muldiv_start = 1'b0;
      bus.funct3       = '0;
      bus.rs1_data     = '0;
      bus.rs2_data     = '0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_output("reset resp", 32'(bus.muldiv_resp), 32'd0);
      check_output("reset out", bus.muldiv_out, 32'd0);
      check_output("reset busy", 32'(bus.muldiv_busy), 32'd0);
      rst = 1'b1;
      $display("[TB] reset released");

      apply_stimulus(3'b000, 32'd7, 32'd6, "MUL 7x6");
      apply_stimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max");
      apply_stimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH -1x-1");
      apply_stimulus(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, "MULHSU -1x2");
      apply_stimulus(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, "DIV -7/2");
      apply_stimulus(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, "REM -7/2");
      apply_stimulus(3'b101, 32'd100, 32'd7, "DIVU 100/7");
      apply_stimulus(3'b111, 32'd100, 32'd7, "REMU 100/7");
      apply_stimulus(3'b101, 32'd5, 32'd0, "DIVU 5/0");
      apply_stimulus(3'b111, 32'd5, 32'd0, "REMU 5/0");
      apply_stimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
      apply_stimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");

      back_to_back(3'b000, 32'd7, 32'd6, 3'b101, 32'd100, 32'd7);

      for (int i = 0; i < 30; i++) begin
         f    = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = $urandom;
         pick = $urandom_range(0, 7);
         if (pick == 0) b = 32'd0;
         else if (pick == 1) b = 32'($urandom_range(1, 15));
         else if (pick == 2) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (pick == 3) b = {1'b1, 31'($urandom_range(0, 255))};
         apply_stimulus(f, a, b, $sformatf("rand%0d f%0d", i, f));
      end

      @(negedge clk);
      bus.muldiv_start = 1'b1;
      bus.funct3       = 3'b000;
      bus.rs1_data     = 32'd3;
      bus.rs2_data     = 32'd5;
      @(posedge clk);
      @(negedge clk);
      bus.muldiv_start = 1'b0;
      repeat (3) @(negedge clk);
      check_output("mid-op busy", 32'(bus.muldiv_busy), 32'd1);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("mid-op reset resp", 32'(bus.muldiv_resp), 32'd0);
      check_output("mid-op reset out", bus.muldiv_out, 32'd0);
      check_output("mid-op reset busy", 32'(bus.muldiv_busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.muldiv_resp) stray++;
      end
      check_output("after reset no resp", 32'(stray), 32'd0);
      apply_stimulus(3'b101, 32'd9, 32'd3, "DIVU 9/3 after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
